// File: rtl/fp32_div_seq.sv
// Iterative IEEE-754 single-precision divider (a_operand / b_operand).
// Restoring mantissa division, one quotient bit per cycle; truncating, no denormals.
module fp32_div_seq #(
    parameter int BIAS  = 127,
    parameter int QBITS = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        Exception,
    output logic        Div_by_zero,
    output logic        Overflow,
    output logic        Underflow
);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        FIN
    } state_t;

    localparam logic signed [9:0] BIAS_S    = 10'(BIAS);
    localparam logic [4:0]        CNT_START = 5'(QBITS - 1);

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [QBITS-1:0]   rem_q, rem_d;
    logic [QBITS-2:0]   den_q, den_d;
    logic [QBITS-1:0]   quo_q, quo_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               busy_d, done_d;
    logic [31:0]        result_d;
    logic               exc_d, dz_d, ovf_d, unf_d;

    logic               sign;
    logic               in_special;
    logic               rem_ge;
    logic [QBITS-1:0]   rem_diff;
    logic signed [9:0]  exp_n;
    logic [22:0]        mant_n;

    function automatic logic is_exc(input logic [31:0] x, input logic [31:0] y);
        return (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF);
    endfunction

    function automatic logic is_special(input logic [31:0] x, input logic [31:0] y);
        return is_exc(x, y) || (x[30:0] == 31'd0) || (y[30:0] == 31'd0);
    endfunction

    assign sign       = a_q[31] ^ b_q[31];
    assign in_special = is_special(a_operand, b_operand);

    // One restoring step: compare the partial remainder against the divisor.
    assign rem_ge   = rem_q >= {1'b0, den_q};
    assign rem_diff = rem_q - {1'b0, den_q};

    // A leading 0 in the quotient means the true mantissa ratio was below 1.0.
    assign exp_n  = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + BIAS_S
                  - (quo_q[QBITS-1] ? 10'sd0 : 10'sd1);
    assign mant_n = quo_q[QBITS-1] ? quo_q[23:1] : quo_q[22:0];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        den_d    = den_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        busy_d   = busy;
        done_d   = done;
        result_d = result;
        exc_d    = Exception;
        dz_d     = Div_by_zero;
        ovf_d    = Overflow;
        unf_d    = Underflow;

        unique case (state_q)
            IDLE: begin
                if (done) begin
                    // Completion cycle: close the handshake and ignore any start.
                    done_d = 1'b0;
                    busy_d = 1'b0;
                end else if (start) begin
                    a_d    = a_operand;
                    b_d    = b_operand;
                    busy_d = 1'b1;
                    exc_d  = 1'b0;
                    dz_d   = 1'b0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    if (in_special) begin
                        state_d = FIN;
                    end else begin
                        rem_d   = {1'b0, 1'b1, a_operand[22:0]};
                        den_d   = {1'b1, b_operand[22:0]};
                        quo_d   = '0;
                        cnt_d   = CNT_START;
                        state_d = DIV;
                    end
                end
            end

            DIV: begin
                rem_d = rem_ge ? {rem_diff[QBITS-2:0], 1'b0} : {rem_q[QBITS-2:0], 1'b0};
                quo_d = {quo_q[QBITS-2:0], rem_ge};
                if (cnt_q == 5'd0) begin
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end

            NORM: begin
                if (exp_n >= 10'sd255) begin
                    ovf_d    = 1'b1;
                    result_d = {sign, 8'hFF, 23'd0};
                end else if (exp_n <= 10'sd0) begin
                    unf_d    = 1'b1;
                    result_d = {sign, 31'd0};
                end else begin
                    result_d = {sign, exp_n[7:0], mant_n};
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            FIN: begin
                if (is_exc(a_q, b_q)) begin
                    exc_d    = 1'b1;
                    result_d = 32'd0;
                end else if (a_q[30:0] == 31'd0) begin
                    result_d = {sign, 31'd0};
                end else begin
                    dz_d     = 1'b1;
                    result_d = {sign, 8'hFF, 23'd0};
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too; they are few and a clean restart costs nothing.
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            den_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            Exception   <= 1'b0;
            Div_by_zero <= 1'b0;
            Overflow    <= 1'b0;
            Underflow   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            den_q       <= den_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            busy        <= busy_d;
            done        <= done_d;
            result      <= result_d;
            Exception   <= exc_d;
            Div_by_zero <= dz_d;
            Overflow    <= ovf_d;
            Underflow   <= unf_d;
        end
    end

endmodule

// File: tb/tb_fp32_div_seq.sv
// Self-checking bench for fp32_div_seq: directed cases, handshake/reset cases and
// random operands compared against an integer-division reference model.
module tb_fp32_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        Exception;
    logic        Div_by_zero;
    logic        Overflow;
    logic        Underflow;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;   // {Exception, Div_by_zero, Overflow, Underflow}
        logic [5:0]  lat;
    } exp_t;

    fp32_div_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_operand  (a_operand),
        .b_operand  (b_operand),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .Exception  (Exception),
        .Div_by_zero(Div_by_zero),
        .Overflow   (Overflow),
        .Underflow  (Underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Quotient mantissa is floor(ma * 2^24 / mb); then normalise and classify.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        m;
        logic        s;
        logic [63:0] ma, mb, q;
        int          e;
        logic [22:0] mant;
        s     = a[31] ^ b[31];
        m.flg = 4'b0000;
        m.lat = 6'd1;
        m.res = 32'd0;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            m.flg = 4'b1000;
        end else if (a[30:0] == 31'd0) begin
            m.res = {s, 31'd0};
        end else if (b[30:0] == 31'd0) begin
            m.res = {s, 8'hFF, 23'd0};
            m.flg = 4'b0100;
        end else begin
            m.lat = 6'd26;
            ma = 64'(a[22:0]) + 64'd8388608;
            mb = 64'(b[22:0]) + 64'd8388608;
            q  = (ma * 64'd16777216) / mb;
            e  = int'(a[30:23]) - int'(b[30:23]) + 127;
            if (q >= 64'd16777216) begin
                mant = q[23:1];
            end else begin
                e    = e - 1;
                mant = q[22:0];
            end
            if (e >= 255) begin
                m.res = {s, 8'hFF, 23'd0};
                m.flg = 4'b0010;
            end else if (e <= 0) begin
                m.res = {s, 31'd0};
                m.flg = 4'b0001;
            end else begin
                m.res = {s, 8'(e), mant};
            end
        end
        return m;
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        exp_t        m;
        int          n;
        bit          seen;
        bit          busy_ok;
        logic [31:0] held;
        m = model(a, b);
        @(negedge clk);
        a_operand = a;
        b_operand = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " accept busy/done/flags"}, {busy, done, Exception, Div_by_zero, Overflow, Underflow},
              {1'b1, 1'b0, 4'b0000});
        n       = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (n < 40 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy) busy_ok = 1'b0;
            if (done) seen = 1'b1;
        end
        check({tag, " latency"}, 64'(n), 64'(m.lat));
        check({tag, " busy held"}, 64'(busy_ok), 64'd1);
        check({tag, " result"}, 64'(result), 64'(m.res));
        check({tag, " flags"}, 64'({Exception, Div_by_zero, Overflow, Underflow}), 64'(m.flg));
        // A start raised during the done cycle must be ignored.
        held      = result;
        start     = 1'b1;
        a_operand = 32'h4000_0000;
        b_operand = 32'h3F80_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " done-cycle close"}, {busy, done, result}, {1'b0, 1'b0, held});
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          mode;
        int          dones;

        rst_n     = 1'b0;
        start     = 1'b0;
        a_operand = '0;
        b_operand = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {busy, done, result, Exception, Div_by_zero, Overflow, Underflow}, 38'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("6/2", 32'h40C0_0000, 32'h4000_0000);
        run_op("1/3", 32'h3F80_0000, 32'h4040_0000);
        check("1/3 literal", 64'(result), 64'h3EAA_AAAA);
        run_op("x/0", 32'h3F80_0000, 32'h0000_0000);
        check("x/0 literal", 64'({result, Div_by_zero}), 64'({32'h7F80_0000, 1'b1}));
        run_op("0/0", 32'h0000_0000, 32'h0000_0000);
        run_op("ovf", 32'h7F00_0000, 32'h3E80_0000);
        check("ovf literal", 64'({result, Overflow}), 64'({32'h7F80_0000, 1'b1}));
        run_op("unf", 32'h0080_0000, 32'h7F00_0000);
        run_op("exc", 32'h7F80_0000, 32'h3F80_0000);
        run_op("neg", 32'hC0C0_0000, 32'h4000_0000);

        // Repeated start pulses while busy: single accept, single done.
        @(negedge clk);
        a_operand = 32'h40C0_0000;
        b_operand = 32'h4000_0000;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            start     = (i < 20) ? i[0] : 1'b0;
            a_operand = $urandom;
            b_operand = $urandom;
        end
        check("busy pulses done count", 64'(dones), 64'd1);
        check("busy pulses result", 64'(result), 64'h4040_0000);

        // Reset in the middle of DIV, then a clean divide.
        @(negedge clk);
        a_operand = 32'h3F80_0000;
        b_operand = 32'h4040_0000;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid-div reset", {busy, done, result, Exception, Div_by_zero, Overflow, Underflow}, 38'd0);
        @(posedge clk);
        #1;
        check("held in reset", {busy, done, result}, 34'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after reset", 32'h40C0_0000, 32'h4000_0000);
        check("after reset literal", 64'(result), 64'h4040_0000);

        // Random operands with a bias toward sensible exponents and special cases.
        for (int k = 0; k < 24; k++) begin
            ra   = $urandom;
            rb   = $urandom;
            mode = int'($urandom_range(0, 9));
            case (mode)
                0: ra[30:23] = 8'hFF;
                1: ra[30:0]  = 31'd0;
                2: rb[30:0]  = 31'd0;
                3, 4, 5, 6: begin
                    ra[30:23] = 8'(112 + $urandom_range(0, 31));
                    rb[30:23] = 8'(112 + $urandom_range(0, 31));
                end
                default: ;
            endcase
            run_op($sformatf("rand%0d", k), ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp32_div_seq.md
Name: fp32_div_seq

Overview:
- Iterative IEEE-754 single-precision divider (a_operand / b_operand). It is the inverse-operation companion to the team's combinational FP32 multiplier.
- Uses a restoring mantissa division that produces one quotient bit per cycle.
- Uses the same special-case and flag conventions as the multiplier: truncation with no rounding, an implicit leading 1 always, and no denormal support.
- Sits on the FP datapath behind a start/done handshake, so the long divide does not sit on a combinational path.

Parameters:
- BIAS, 127, exponent bias.
- QBITS, 25, quotient bits generated. This is 24 mantissa bits plus 1 normalisation bit. It is fixed for FP32 and is not meant to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- a_operand  input  32  dividend; captured at the accepted start edge
- b_operand  input  32  divisor; captured at the accepted start edge
- busy  output  1  high from the start-accept edge until the edge that raises done (inclusive)
- done  output  1  one-cycle pulse; result and flags are valid from this cycle onwards
- result  output  32  quotient; held until the next accepted start
- Exception  output  1  either operand exponent field equals 8'hFF
- Div_by_zero  output  1  b_operand[30:0]==0, and a is neither zero nor Exception
- Overflow  output  1  result exponent is at least 255
- Underflow  output  1  result exponent is at most 0

Behaviour:
- Reset: when rst_n is low at an edge, the FSM goes to IDLE, and busy, done, result and all flags become 0. This applies even mid-division; the partial quotient is discarded.
- States: IDLE, DIV, NORM, FIN.
- IDLE: at an edge with start=1, the block does the following.
  - Latches the operands and sign = a[31]^b[31].
  - Clears done and the flags, and sets busy.
  - If a special case applies, goes to FIN. Otherwise loads R={1'b0,1'b1,a[22:0]} (25 bits), D={1'b1,b[22:0]}, cnt=24, and goes to DIV.
- Special-case priority:
  1. Exception → result 32'd0.
  2. a zero (a[30:0]==0) → {sign,31'd0}.
  3. b zero → {sign,8'hFF,23'd0} with Div_by_zero=1.
- DIV: one iteration per edge.
  - If R>=D: q[cnt]=1 and R=(R-D)<<1.
  - Else: q[cnt]=0 and R=R<<1.
  - cnt decrements. After the cnt==0 iteration, the FSM goes to NORM. That is 25 DIV edges in total.
- NORM:
  - Compute the exponent as a signed 10-bit value: e = a[30:23] - b[30:23] + BIAS - (q[24] ? 0 : 1).
  - Mantissa is q[23:1] when q[24]==1, else q[22:0]. Lower bits are truncated.
  - If e>=255: Overflow=1, result {sign,8'hFF,23'd0}.
  - Else if e<=0: Underflow=1, result {sign,31'd0}.
  - Else: result {sign,e[7:0],mantissa}.
  - Raise done, then go to IDLE.
- FIN (special-case path): write the special result and flags, raise done, then go to IDLE.
- Latency:
  - Normal path: done is high for the cycle following the 26th edge after the accept edge.
  - Special-case path: done is high for the cycle following the 1st edge after the accept edge.
- Handshake:
  - start is ignored while busy.
  - start in the same cycle that done is high is ignored. The FSM returns to IDLE at that edge.
  - A start is accepted at the next edge if it is still high.
  - done drops at the edge after it rises.
  - busy drops at that same edge.
- Exactly one flag can be set per operation. All flags are cleared at the next accepted start.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2): result 0x40400000, no flags, done on the 26th edge after accept, busy high throughout.
- 0x3F800000 / 0x40400000 (1/3): q[24]=0 path; result 0x3EAAAAAA (truncated); done at the 26th edge.
- 0x3F800000 / 0x00000000: Div_by_zero=1, result 0x7F800000, done 1 edge after accept. Repeat with a=0 and b=0: result 0x00000000, Div_by_zero=0.
- 0x7F000000 / 0x3E800000: Overflow=1, result 0x7F800000. 0x00800000 / 0x7F000000: Underflow=1, result 0x00000000.
- 0x7F800000 / 0x3F800000: Exception=1, result 0x00000000. Pulse start repeatedly while busy during a normal divide: no re-accept, and exactly one done pulse.
- Drive rst_n low at DIV iteration 10, then release and start 0x40C00000 / 0x40000000: all outputs 0 during reset; the new operation completes with result 0x40400000 at the nominal latency.
